// File: rtl/stepper_axis_ctrl_if.sv
// Move-command interface between the move sequencer and the stepper axis
// controller.
//   master : sequencer side, drives start/steps/dir_in/period/abort and
//            observes busy/done/steps_left
//   slave  : controller side, the mirror image
interface stepper_axis_ctrl_if #(
  parameter int STEP_W   = 16,
  parameter int PERIOD_W = 16
);
  logic                start;
  logic [STEP_W-1:0]   steps;
  logic                dir_in;
  logic [PERIOD_W-1:0] period;
  logic                abort;
  logic                busy;
  logic                done;
  logic [STEP_W-1:0]   steps_left;

  modport master (
    output start, steps, dir_in, period, abort,
    input  busy, done, steps_left
  );

  modport slave (
    input  start, steps, dir_in, period, abort,
    output busy, done, steps_left
  );
endinterface

// File: rtl/stepper_axis_ctrl.sv
// Single-axis stepper pulse generator driving the STEP/DIR pins of an
// external driver IC.
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   cmd      : move command interface (start/steps/dir_in/period/abort in,
//              busy/done/steps_left out)
//   step_out : STEP pin, registered
//   dir_out  : DIR pin, registered, holds its value between moves
//
// state    | meaning
// IDLE     | waiting for start; dir_out and steps_left hold
// SETUP    | dir_out settled, waiting DIR_SETUP_CYCLES before first step
// PULSE_HI | step_out high for PULSE_CYCLES
// PULSE_LO | step_out low for eff - PULSE_CYCLES
module stepper_axis_ctrl #(
  parameter int STEP_W           = 16,
  parameter int PERIOD_W         = 16,
  parameter int PULSE_CYCLES     = 2,
  parameter int DIR_SETUP_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  stepper_axis_ctrl_if.slave   cmd,
  output logic                 step_out,
  output logic                 dir_out
);

  localparam int CW_SETUP = $clog2(DIR_SETUP_CYCLES + 1);
  localparam int CW_PULSE = $clog2(PULSE_CYCLES + 1);
  localparam int CW_A     = (CW_SETUP > CW_PULSE) ? CW_SETUP : CW_PULSE;
  localparam int CNT_W    = (CW_A > PERIOD_W) ? CW_A : PERIOD_W;

  localparam logic [CNT_W-1:0]    SETUP_LOAD = CNT_W'(DIR_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]    HI_LOAD    = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] MIN_EFF    = PERIOD_W'(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE_HI, PULSE_LO} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [PERIOD_W-1:0] eff, eff_n;
  logic                abort_pend, abort_pend_n;
  logic                step_n, dir_n, busy, busy_n, done, done_n;
  logic [STEP_W-1:0]   left, left_n;
  logic [PERIOD_W-1:0] eff_calc;

  // Period must leave at least one low clock after the high pulse.
  assign eff_calc = (cmd.period < MIN_EFF) ? MIN_EFF : cmd.period;

  assign cmd.busy       = busy;
  assign cmd.done       = done;
  assign cmd.steps_left = left;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      eff        <= '0;
      abort_pend <= 1'b0;
      step_out   <= 1'b0;
      dir_out    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      left       <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      eff        <= eff_n;
      abort_pend <= abort_pend_n;
      step_out   <= step_n;
      dir_out    <= dir_n;
      busy       <= busy_n;
      done       <= done_n;
      left       <= left_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    eff_n        = eff;
    abort_pend_n = abort_pend;
    step_n       = step_out;
    dir_n        = dir_out;
    busy_n       = busy;
    done_n       = 1'b0;
    left_n       = left;

    unique case (state)
      IDLE: begin
        if (cmd.start && !cmd.abort) begin
          left_n = cmd.steps;
          eff_n  = eff_calc;
          if (cmd.steps == '0) begin
            done_n = 1'b1;
          end else begin
            busy_n  = 1'b1;
            dir_n   = cmd.dir_in;
            cnt_n   = SETUP_LOAD;
            state_n = SETUP;
          end
        end
      end
      SETUP: begin
        if (cmd.abort) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt == '0) begin
          step_n       = 1'b1;
          cnt_n        = HI_LOAD;
          abort_pend_n = 1'b0;
          state_n      = PULSE_HI;
        end
      end
      PULSE_HI: begin
        // An abort during the high time is remembered so the pulse still
        // finishes at full width and is counted.
        if (cmd.abort) abort_pend_n = 1'b1;
        if (cnt == '0) begin
          step_n = 1'b0;
          if (left != '0) left_n = left - STEP_W'(1);
          if (cmd.abort || abort_pend) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n   = CNT_W'(eff - MIN_EFF);
            state_n = PULSE_LO;
          end
        end
      end
      PULSE_LO: begin
        if (cmd.abort || (cnt == '0 && left == '0)) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt == '0) begin
          step_n       = 1'b1;
          cnt_n        = HI_LOAD;
          abort_pend_n = 1'b0;
          state_n      = PULSE_HI;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/stepper_axis_ctrl.md
Name: stepper_axis_ctrl

Overview:
Single-axis stepper pulse generator with direction, programmable step period, minimum pulse width and direction-setup time.
It drives STEP/DIR inputs of an external stepper driver IC.
It replaces the external step-rate clock with an internal per-step period counter and adds abort and remaining-step reporting.
It sits between the move sequencer (start/steps/dir/period) and the motor pins.

Parameters:
STEP_W, 16, width of step count and steps_left
PERIOD_W, 16, width of period input (clock cycles between step rising edges)
PULSE_CYCLES, 2, step_out high time in clocks (>=1)
DIR_SETUP_CYCLES, 4, clocks from dir_out change to first step rising edge (>=1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  begin move; sampled only in IDLE
steps  input  STEP_W  number of steps, unsigned; latched on accepted start
dir_in  input  1  direction; latched on accepted start
period  input  PERIOD_W  clocks between step rising edges; latched on accepted start
abort  input  1  stop move after current pulse
step_out  output  1  STEP pin, registered
dir_out  output  1  DIR pin, registered
busy  output  1  high from start acceptance to completion
done  output  1  one-cycle pulse on completion or abort
steps_left  output  STEP_W  remaining steps, registered

Behaviour:
- Reset (async, reset_n low):
  - step_out=0, dir_out=0, busy=0, done=0, steps_left=0, state IDLE.
  - Takes effect immediately mid-move; step_out drops with no wait for pulse completion.
- States: IDLE, SETUP, PULSE_HI, PULSE_LO. A single down-counter times each state.
- Effective period: eff = max(period, PULSE_CYCLES+1), computed at latch time.
- IDLE, start=1, abort=0 at edge T:
  - Latch steps, dir_in and eff. steps_left=steps at T+1.
  - If steps==0: stay IDLE, busy stays 0, done=1 at T+1 only, dir_out unchanged.
  - Else: busy=1 and dir_out=dir_in at T+1; enter SETUP.
- SETUP: lasts DIR_SETUP_CYCLES clocks. The first step_out rising edge is at T+1+DIR_SETUP_CYCLES.
- PULSE_HI:
  - step_out=1 for exactly PULSE_CYCLES clocks.
  - On leaving: step_out=0 and steps_left decrements by 1 on the same edge.
- PULSE_LO:
  - Lasts eff-PULSE_CYCLES clocks.
  - Then, if steps_left!=0, enter PULSE_HI, giving rising edges exactly eff clocks apart.
  - Otherwise go to IDLE: busy=0 and done=1 for one cycle.
  - Completion edge = T+1+DIR_SETUP_CYCLES+N*eff.
- start while busy: ignored; latched values do not change mid-move.
- abort:
  - In SETUP or PULSE_LO: next edge goes to IDLE, busy=0, done=1, step_out stays 0, steps_left holds the remaining count.
  - In PULSE_HI: the current pulse completes its full PULSE_CYCLES and is counted (steps_left decrements), then IDLE with done=1 on that same falling edge.
  - In IDLE: start is ignored; abort wins on simultaneous start+abort; no done pulse.
- dir_out holds its value after a move ends. It changes only on an accepted start with steps!=0.
- Widths: steps_left never wraps; decrement occurs only when nonzero. Period counter is PERIOD_W wide; eff max = 2^PERIOD_W-1.
- done never coincides with busy=1. busy falls on the same edge done rises.

Test Plan:
- Normal move (D=4, P=2), steps=3, period=10, dir_in=1, start at edge T:
  - busy=1 and dir_out=1 at T+1.
  - step_out rises at T+5, T+15, T+25, each high 2 clocks.
  - steps_left goes 2,1,0 at T+7, T+17, T+27.
  - busy=0 and done=1 at T+35, done low at T+36.
- Period clamp: steps=2, period=1 -> eff=3; rises at T+5 and T+8; done at T+11.
- Zero steps: steps=0, start -> done=1 at T+1 only; busy never high; dir_out unchanged.
- Abort in PULSE_HI:
  - steps=5, period=10; abort pulsed at T+6 (during first pulse).
  - Pulse still falls at T+7; steps_left=4; done=1 and busy=0 at T+7.
  - No further step_out edges.
- Abort in PULSE_LO: steps=5, abort at T+10 -> IDLE at T+11, done=1, steps_left=4.
- Ignored start and async reset:
  - start with new steps/dir mid-move -> no change to count, dir or timing.
  - reset_n low mid-PULSE_HI -> step_out, busy and steps_left go 0 immediately, without waiting for a clock edge.
  - After release, a new start behaves as in the normal-move case.
